// File: rtl/spi_gpu_pkg.sv
// Shared definitions for the SPI command controller: opcodes, FSM states,
// byte width and opcode legality.
// Optional build macro: SPI_CMD_ERR_CNT_EN (makes opcode 11 a legal STATUS command).
package spi_gpu_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RFETCH,
        ST_RWAIT,
        ST_RDATA,
        ST_DISCARD
    } state_e;

    // Opcode 11 is only meaningful when the error counter is built in.
    function automatic logic op_is_legal(input logic [1:0] op);
`ifdef SPI_CMD_ERR_CNT_EN
        return 1'b1;
`else
        return op != OP_STATUS;
`endif
    endfunction

endpackage

// File: rtl/spi_cmd_addr_ctr.sv
// Loadable register-address counter that wraps modulo 2^ADDR_W on increment.
module spi_cmd_addr_ctr
    import spi_gpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Load takes priority over increment; natural overflow gives the wrap.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/spi_cmd_controller.sv
// SPI command sequencer: decodes opcode/address/data bytes framed by slave
// select into register-file writes and reads, and returns read data to the
// byte shifter. Optional build macro: SPI_CMD_ERR_CNT_EN adds an 8-bit
// saturating error counter readable with the STATUS opcode (11).
module spi_cmd_controller
    import spi_gpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_active,
    input  logic                  rx_valid,
    input  logic [SPI_BYTE_W-1:0] rx_data,
    output logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  tx_load,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic                  reg_we,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic                  reg_re,
    input  logic [DATA_W-1:0]     reg_rdata,
    output logic                  busy,
    output logic                  err
);

    state_e                  state_q;
    logic                    is_write_q;
    logic                    reg_we_q;
    logic                    reg_re_q;
    logic                    tx_load_q;
    logic                    err_q;
    logic [SPI_BYTE_W-1:0]   tx_data_q;
    logic [DATA_W-1:0]       reg_wdata_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       addr_load_val;
    logic [1:0]              op;
    logic                    byte_ok;
    logic                    addr_load;
    logic                    addr_inc;

    assign op            = rx_data[7:6];
    assign byte_ok       = frame_active && rx_valid;
    assign addr_load_val = ADDR_W'(rx_data);
    assign addr_load     = (state_q == ST_ADDR) && byte_ok;
    // Advance after a strobe that actually reached the register file, or
    // once read data has been captured for transmission.
    assign addr_inc      = frame_active && (reg_we_q || (state_q == ST_RWAIT));

    spi_cmd_addr_ctr #(
        .ADDR_W(ADDR_W)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (addr_load),
        .load_val_i(addr_load_val),
        .inc_i     (addr_inc),
        .addr_o    (addr_q)
    );

`ifdef SPI_CMD_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       cnt_bump;
    logic       status_hit;

    assign status_hit = (state_q == ST_IDLE) && byte_ok && (op == OP_STATUS);
    assign cnt_bump   = ((state_q == ST_IDLE) && byte_ok && !op_is_legal(op)) ||
                        ((state_q == ST_ADDR) && !frame_active);

    // Saturating count of illegal opcodes and frames aborted in ADDR; a STATUS read clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (status_hit) begin
            err_cnt_q <= '0;
        end else if (cnt_bump && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`endif

    // Command FSM with registered strobes and response byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            tx_load_q   <= 1'b0;
            err_q       <= 1'b0;
            tx_data_q   <= '0;
            reg_wdata_q <= '0;
        end else begin
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            tx_load_q <= 1'b0;
            if (!frame_active) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_valid) begin
                            if (!op_is_legal(op)) begin
                                err_q   <= 1'b1;
                                state_q <= ST_DISCARD;
                            end else begin
                                err_q <= 1'b0;
                                case (op)
                                    OP_WRITE: begin
                                        is_write_q <= 1'b1;
                                        state_q    <= ST_ADDR;
                                    end
                                    OP_READ: begin
                                        is_write_q <= 1'b0;
                                        state_q    <= ST_ADDR;
                                    end
                                    OP_STATUS: begin
`ifdef SPI_CMD_ERR_CNT_EN
                                        tx_data_q <= err_cnt_q;
                                        tx_load_q <= 1'b1;
`endif
                                        state_q   <= ST_DISCARD;
                                    end
                                    default: state_q <= ST_DISCARD;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rx_valid) begin
                            if (is_write_q) begin
                                state_q <= ST_WDATA;
                            end else begin
                                reg_re_q <= 1'b1;
                                state_q  <= ST_RFETCH;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rx_valid) begin
                            reg_we_q    <= 1'b1;
                            reg_wdata_q <= DATA_W'(rx_data);
                        end
                    end
                    ST_RFETCH: state_q <= ST_RWAIT;
                    ST_RWAIT: begin
                        tx_data_q <= SPI_BYTE_W'(reg_rdata);
                        tx_load_q <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                    ST_RDATA: begin
                        if (rx_valid) begin
                            reg_re_q <= 1'b1;
                            state_q  <= ST_RFETCH;
                        end
                    end
                    ST_DISCARD: state_q <= ST_DISCARD;
                    default:    state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign reg_addr  = addr_q;
    // Strobes are qualified by frame_active so one already scheduled for the
    // cycle in which the frame ends never reaches the register file.
    assign reg_we    = reg_we_q && frame_active;
    assign reg_re    = reg_re_q && frame_active;
    assign reg_wdata = reg_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed testbench for spi_cmd_controller with a behavioural register file.
module tb_spi_cmd_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] reg_addr;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       err;

    int checks = 0;
    int passed = 0;

    spi_cmd_controller #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_active(frame_active),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .reg_addr    (reg_addr),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: read data valid one cycle after reg_re.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Event logs, sampled mid-cycle.
    logic [7:0]  wr_a[$];
    logic [7:0]  wr_d[$];
    int unsigned wr_c[$];
    logic [7:0]  tx_d[$];
    int unsigned tx_c[$];
    int          n_re = 0;
    int          n_ov = 0;
    always @(negedge clk) begin
        if (reg_we) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wdata);
            wr_c.push_back(cyc);
        end
        if (reg_re) n_re = n_re + 1;
        if (tx_load) begin
            tx_d.push_back(tx_data);
            tx_c.push_back(cyc);
        end
        if (reg_we && reg_re) n_ov = n_ov + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int unsigned c);
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc;
        tick();
        rx_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_on;
        frame_active = 1'b1;
        tick();
    endtask

    task automatic frame_off;
        frame_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks++; if ({tx_data, tx_load} !== 9'h0) $display("FAIL reset_tx got %h/%b want 00/0", tx_data, tx_load); else passed++;
        checks++; if ({reg_we, reg_re} !== 2'b00) $display("FAIL reset_strobes got we=%b re=%b want 0/0", reg_we, reg_re); else passed++;
        checks++; if (reg_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", reg_addr); else passed++;
        checks++; if (reg_wdata !== 8'h00) $display("FAIL reset_wdata got %h want 00", reg_wdata); else passed++;
        checks++; if ({busy, err} !== 2'b00) $display("FAIL reset_busy_err got %b%b want 00", busy, err); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_burst_write;
        int unsigned c[5];
        int          b;
        int          r;
        logic [7:0]  ea[3];
        logic [7:0]  ed[3];
        ea = '{8'h10, 8'h11, 8'h12};
        ed = '{8'hAA, 8'hBB, 8'hCC};
        b = wr_a.size();
        r = n_re;
        frame_on();
        send(8'h40, c[0]);
        checks++; if (busy !== 1'b1) $display("FAIL wr_busy got %b want 1", busy); else passed++;
        send(8'h10, c[1]);
        send(8'hAA, c[2]);
        send(8'hBB, c[3]);
        send(8'hCC, c[4]);
        frame_off();
        checks++; if (wr_a.size() !== b + 3) $display("FAIL wr_count got %0d want %0d", wr_a.size() - b, 3); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_a[b+i] !== ea[i] || wr_d[b+i] !== ed[i] || wr_c[b+i] !== c[i+2] + 1)
                $display("FAIL wr_beat%0d got %h/%h@%0d want %h/%h@%0d", i, wr_a[b+i], wr_d[b+i], wr_c[b+i], ea[i], ed[i], c[i+2] + 1);
            else passed++;
        end
        checks++; if (n_re !== r) $display("FAIL wr_no_read got %0d reads want 0", n_re - r); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL wr_idle_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_burst_read;
        int unsigned c[5];
        int          bw;
        int          bt;
        int          r;
        logic [7:0]  ed[3];
        ed = '{8'h5A, 8'hC3, 8'h77};
        frame_on();
        send(8'h40, c[0]);
        send(8'h20, c[1]);
        send(8'h5A, c[2]);
        send(8'hC3, c[3]);
        send(8'h77, c[4]);
        frame_off();
        bw = wr_a.size();
        bt = tx_d.size();
        r  = n_re;
        frame_on();
        send(8'h80, c[0]);
        send(8'h20, c[1]);
        send(8'h00, c[2]);
        send(8'h00, c[3]);
        frame_off();
        checks++; if (tx_d.size() !== bt + 3) $display("FAIL rd_count got %0d want %0d", tx_d.size() - bt, 3); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_d[bt+i] !== ed[i] || tx_c[bt+i] !== c[i+1] + 3)
                $display("FAIL rd_beat%0d got %h@%0d want %h@%0d", i, tx_d[bt+i], tx_c[bt+i], ed[i], c[i+1] + 3);
            else passed++;
        end
        checks++; if (n_re !== r + 3) $display("FAIL rd_strobes got %0d want 3", n_re - r); else passed++;
        checks++; if (wr_a.size() !== bw) $display("FAIL rd_no_write got %0d want 0", wr_a.size() - bw); else passed++;
        checks++; if (tx_data !== 8'h77) $display("FAIL rd_hold got %h want 77", tx_data); else passed++;
    endtask

    task automatic test_wrap;
        int unsigned c[4];
        int          b;
        b = wr_a.size();
        frame_on();
        send(8'h40, c[0]);
        send(8'hFF, c[1]);
        send(8'h01, c[2]);
        send(8'h02, c[3]);
        frame_off();
        checks++; if (wr_a.size() !== b + 2) $display("FAIL wrap_count got %0d want 2", wr_a.size() - b); else passed++;
        checks++; if (wr_a[b] !== 8'hFF || wr_d[b] !== 8'h01) $display("FAIL wrap_first got %h/%h want ff/01", wr_a[b], wr_d[b]); else passed++;
        checks++; if (wr_a[b+1] !== 8'h00 || wr_d[b+1] !== 8'h02) $display("FAIL wrap_second got %h/%h want 00/02", wr_a[b+1], wr_d[b+1]); else passed++;
    endtask

    task automatic test_abort;
        int unsigned c;
        int          b;
        b = wr_a.size();
        frame_on();
        send(8'h40, c);
        send(8'h30, c);
        frame_active = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        tick();
        checks++; if (reg_addr !== 8'h30) $display("FAIL abort_addr_kept got %h want 30", reg_addr); else passed++;
        // Frame ends in the very cycle a write strobe was scheduled.
        frame_on();
        send(8'h40, c);
        send(8'h50, c);
        rx_data  = 8'h66;
        rx_valid = 1'b1;
        tick();
        rx_valid     = 1'b0;
        frame_active = 1'b0;
        tick();
        tick();
        checks++; if (wr_a.size() !== b) $display("FAIL abort_no_write got %0d writes want 0", wr_a.size() - b); else passed++;
        checks++; if (reg_addr !== 8'h50) $display("FAIL abort_no_inc got %h want 50", reg_addr); else passed++;
        frame_on();
        send(8'h40, c);
        send(8'h05, c);
        send(8'h99, c);
        frame_off();
        checks++; if (wr_a.size() !== b + 1 || wr_a[b] !== 8'h05 || wr_d[b] !== 8'h99)
            $display("FAIL abort_recover got n=%0d %h/%h want n=1 05/99", wr_a.size() - b, wr_a[b], wr_d[b]);
        else passed++;
    endtask

    task automatic test_opcodes;
        int unsigned c;
        int          b;
`ifdef SPI_CMD_ERR_CNT_EN
        for (int i = 0; i < 2; i++) begin
            frame_on();
            send(8'h40, c);
            frame_off();
        end
        b = tx_d.size();
        frame_on();
        send(8'hC0, c);
        frame_off();
        checks++; if (tx_d.size() !== b + 1 || tx_d[b] !== 8'h02 || tx_c[b] !== c + 1)
            $display("FAIL status_count got n=%0d %h@%0d want n=1 02@%0d", tx_d.size() - b, tx_d[b], tx_c[b], c + 1);
        else passed++;
        checks++; if (err !== 1'b0) $display("FAIL status_err got %b want 0", err); else passed++;
        b = tx_d.size();
        frame_on();
        send(8'hC0, c);
        frame_off();
        checks++; if (tx_d.size() !== b + 1 || tx_d[b] !== 8'h00)
            $display("FAIL status_cleared got n=%0d %h want n=1 00", tx_d.size() - b, tx_d[b]);
        else passed++;
`else
        b = wr_a.size();
        frame_on();
        send(8'hC0, c);
        checks++; if (err !== 1'b1 || busy !== 1'b1) $display("FAIL illegal_err got err=%b busy=%b want 1/1", err, busy); else passed++;
        send(8'h40, c);
        send(8'h10, c);
        send(8'h22, c);
        frame_off();
        checks++; if (wr_a.size() !== b) $display("FAIL illegal_discard got %0d writes want 0", wr_a.size() - b); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL illegal_sticky got %b want 1", err); else passed++;
        frame_on();
        send(8'h00, c);
        checks++; if (err !== 1'b0) $display("FAIL illegal_clear got %b want 0", err); else passed++;
        frame_off();
`endif
    endtask

    task automatic test_reset_mid_burst;
        int unsigned c;
        frame_on();
        send(8'h40, c);
        send(8'h77, c);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        checks++; if (reg_we !== 1'b1 || reg_wdata !== 8'h11) $display("FAIL mid_strobe got we=%b %h want 1 11", reg_we, reg_wdata); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0 || tx_load !== 1'b0) $display("FAIL mid_rst_strobes got %b%b%b want 000", reg_we, reg_re, tx_load); else passed++;
        checks++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) $display("FAIL mid_rst_addr got %h/%h want 00/00", reg_addr, reg_wdata); else passed++;
        checks++; if (tx_data !== 8'h00 || busy !== 1'b0 || err !== 1'b0) $display("FAIL mid_rst_misc got tx=%h busy=%b err=%b want 00/0/0", tx_data, busy, err); else passed++;
        frame_active = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || reg_addr !== 8'h00) $display("FAIL mid_rst_after got busy=%b addr=%h want 0/00", busy, reg_addr); else passed++;
    endtask

    task automatic test_exclusive;
        checks++; if (n_ov !== 0) $display("FAIL we_re_overlap got %0d cycles want 0", n_ov); else passed++;
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_burst_read();
        test_wrap();
        test_abort();
        test_opcodes();
        test_reset_mid_burst();
        test_exclusive();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
- Command sequencer between the SPI byte shifter and the GPU register file.
- Consumes received bytes framed by slave select and decodes opcode/address/data packets.
- Issues register writes and reads, and supplies response bytes to the shifter for transmission on MISO.

Parameters:
- ADDR_W, 8, register address width; auto-increment wraps modulo 2^ADDR_W.
- DATA_W, 8, register data width; fixed equal to SPI byte width, other values unsupported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_active  in  1  synchronized slave select, active high; high for the whole frame
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte
- rx_data  in  8  received byte
- tx_data  out  8  byte for the shifter to send next
- tx_load  out  1  one-cycle pulse: shifter latches tx_data
- reg_addr  out  ADDR_W  register address
- reg_we  out  1  one-cycle write strobe
- reg_wdata  out  DATA_W  write data
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  DATA_W  read data, valid exactly one cycle after reg_re
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky illegal-opcode flag; cleared by the next opcode byte that decodes as legal

Behaviour:
- Reset values: all outputs 0, including tx_data. State IDLE, address register 0.
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-low (rst_n).
- Opcode byte: bits [7:6] are the command, bits [5:0] are ignored.
  - 00 NOP
  - 01 WRITE
  - 10 READ
  - 11 STATUS (see Optional Feature)
- States: IDLE, ADDR, WDATA, RFETCH, RWAIT, RDATA, DISCARD.
- IDLE:
  - rx_valid while frame_active: decode rx_data.
  - NOP -> DISCARD.
  - WRITE or READ -> ADDR.
  - Illegal opcode -> DISCARD with err set.
- ADDR, on rx_valid:
  - Address register <= rx_data[ADDR_W-1:0].
  - WRITE -> WDATA.
  - READ -> RFETCH.
- WDATA, on rx_valid:
  - Next cycle: reg_we=1, reg_addr=current address, reg_wdata=rx_data.
  - Address increments after the strobe. Stay in WDATA (burst write).
- RFETCH: single cycle; reg_re=1 at the current address; -> RWAIT.
- RWAIT: single cycle; tx_data <= reg_rdata, tx_load=1; address increments; -> RDATA.
- RDATA, on rx_valid (dummy byte from master): -> RFETCH, prefetching the next address.
  - Response latency from rx_valid to tx_load is 3 cycles; the shifter must tolerate this.
- DISCARD: ignores all bytes until the frame ends.
- frame_active low in any state:
  - Return to IDLE on the next edge.
  - A reg_we or reg_re already scheduled for that cycle is suppressed.
  - Address register is retained; err is retained.
- rx_valid while frame_active is low is ignored.
- A rx_valid that coincides with frame_active falling is dropped.
- Address wrap: 2^ADDR_W-1 increments to 0.
- At most one of reg_we or reg_re is high in any cycle.

Optional Feature:
- Macro: SPI_CMD_ERR_CNT_EN.
- Defined:
  - 8-bit saturating counter increments on each illegal opcode and on each frame aborted in ADDR. Saturates at 0xFF.
  - Opcode 11 is STATUS: the next cycle loads tx_data = counter with a tx_load pulse, then counter clears -> DISCARD.
  - Opcode 11 is legal and does not set err.
- Not defined: opcode 11 is illegal -> DISCARD with err set; no counter logic.

Decomposition:
- Shared package spi_gpu_pkg:
  - Opcode constants OP_NOP, OP_WRITE, OP_READ, OP_STATUS.
  - State enum/localparams.
  - SPI_BYTE_W = 8.
- One natural sub-module: spi_cmd_addr_ctr, a loadable, wrapping auto-increment address counter.
- Decode and FSM remain in the top module.

Test Plan:
- Burst write: frame 0x40, 0x10, 0xAA, 0xBB, 0xCC -> reg_we pulses at 0x10/0xAA, 0x11/0xBB, 0x12/0xCC; no reg_re.
- Burst read: regs 0x20=0x5A, 0x21=0xC3; frame 0x80, 0x20, dummy, dummy -> tx_load with 0x5A, then 0xC3, each 3 cycles after its triggering rx_valid.
- Wrap: write 0x40, 0xFF, 0x01, 0x02 -> writes land at 0xFF then 0x00.
- Abort: frame_active drops after 0x40, 0x30 -> no reg_we, state IDLE next cycle, busy=0; next frame decodes normally.
- Illegal and STATUS opcodes:
  - Without macro: 0xC0 -> err=1, following bytes ignored; next frame 0x00 -> err=0.
  - With macro: two illegal frames, then 0xC0 -> tx_data=0x02, then counter reads 0.
- Reset mid-burst: rst_n low during WDATA -> all outputs 0 immediately, state IDLE, address 0.
